prefetch_buffer: RTL and testbench



---
 rtl/prefetch_buffer.sv | 161 ++++++++++++++++
 tb/tb_prefetch_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// Fully associative, age-ordered prefetch candidate buffer. It accepts ISB prefetches, issues them
// to memory oldest-first, captures out-of-order responses and serves demand lookups.
module prefetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pf_v,
    input  logic [AW-1:0]          pf_addr,
    output logic                   pf_drop,
    output logic                   mem_req_v,
    output logic [AW-1:0]          mem_req_addr,
    input  logic                   mem_req_rdy,
    input  logic                   mem_resp_v,
    input  logic [AW-1:0]          mem_resp_addr,
    input  logic [DW-1:0]          mem_resp_data,
    input  logic                   dem_v,
    input  logic [AW-1:0]          dem_addr,
    output logic                   dem_hit,
    output logic [DW-1:0]          dem_data,
    output logic                   dem_pending,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] AgeMax = IW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StQueued, StInflight, StReady} ent_st_e;

    ent_st_e       st_q   [DEPTH];
    ent_st_e       st_d   [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [IW-1:0] age_q  [DEPTH];
    logic [IW-1:0] age_d  [DEPTH];

    logic          dup;
    logic          idle_found, rdy_found, que_found;
    logic [IW-1:0] idle_idx, rdy_idx, que_idx;
    logic [IW-1:0] rdy_age, que_age;
    logic          alloc_v, issue_slot, issue_v;
    logic [IW-1:0] alloc_idx;

    logic          pf_drop_d, mem_req_v_d, dem_hit_d, dem_pending_d;
    logic [AW-1:0] mem_req_addr_d;
    logic [DW-1:0] dem_data_d;
    logic [IW:0]   occupancy_d;

    // Candidate search over pre-update state; strict '>' keeps ties on the lowest index.
    always_comb begin
        dup        = 1'b0;
        idle_found = 1'b0;
        idle_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        rdy_age    = '0;
        que_found  = 1'b0;
        que_idx    = '0;
        que_age    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (st_q[i] != StIdle && addr_q[i] == pf_addr) dup = 1'b1;
            if (st_q[i] == StIdle && !idle_found) begin
                idle_found = 1'b1;
                idle_idx   = IW'(i);
            end
            if (st_q[i] == StReady && (!rdy_found || age_q[i] > rdy_age)) begin
                rdy_found = 1'b1;
                rdy_idx   = IW'(i);
                rdy_age   = age_q[i];
            end
            if (st_q[i] == StQueued && (!que_found || age_q[i] > que_age)) begin
                que_found = 1'b1;
                que_idx   = IW'(i);
                que_age   = age_q[i];
            end
        end
    end

    always_comb begin
        alloc_v        = pf_v && !dup && (idle_found || rdy_found);
        alloc_idx      = idle_found ? idle_idx : rdy_idx;
        pf_drop_d      = pf_v && !alloc_v;
        issue_slot     = !mem_req_v || mem_req_rdy;
        issue_v        = issue_slot && que_found;
        mem_req_v_d    = issue_slot ? que_found : mem_req_v;
        mem_req_addr_d = issue_v ? addr_q[que_idx] : mem_req_addr;
        dem_hit_d      = 1'b0;
        dem_pending_d  = 1'b0;
        dem_data_d     = '0;
        occupancy_d    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            st_d[i]   = st_q[i];
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
            age_d[i]  = age_q[i];
            if (alloc_v && st_q[i] != StIdle && alloc_idx != IW'(i) && age_q[i] != AgeMax) begin
                age_d[i] = age_q[i] + IW'(1);
            end
            if (mem_resp_v && st_q[i] == StInflight && addr_q[i] == mem_resp_addr) begin
                st_d[i]   = StReady;
                data_d[i] = mem_resp_data;
            end
            if (dem_v && st_q[i] != StIdle && addr_q[i] == dem_addr) begin
                case (st_q[i])
                    StReady: begin
                        dem_hit_d  = 1'b1;
                        dem_data_d = data_q[i];
                        st_d[i]    = StIdle;
                    end
                    StInflight: dem_pending_d = 1'b1;
                    StQueued: begin
                        if (!(issue_v && que_idx == IW'(i))) st_d[i] = StIdle;
                    end
                    default: ;
                endcase
            end
            if (issue_v && que_idx == IW'(i)) st_d[i] = StInflight;
            // Allocation wins the slot even if a demand frees the same READY entry.
            if (alloc_v && alloc_idx == IW'(i)) begin
                st_d[i]   = StQueued;
                addr_d[i] = pf_addr;
                age_d[i]  = '0;
            end
            if (st_d[i] != StIdle) occupancy_d = occupancy_d + (IW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i]   <= StIdle;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
            pf_drop      <= 1'b0;
            mem_req_v    <= 1'b0;
            mem_req_addr <= '0;
            dem_hit      <= 1'b0;
            dem_data     <= '0;
            dem_pending  <= 1'b0;
            occupancy    <= '0;
        end else begin
            st_q         <= st_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            age_q        <= age_d;
            pf_drop      <= pf_drop_d;
            mem_req_v    <= mem_req_v_d;
            mem_req_addr <= mem_req_addr_d;
            dem_hit      <= dem_hit_d;
            dem_data     <= dem_data_d;
            dem_pending  <= dem_pending_d;
            occupancy    <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomised and directed bench for prefetch_buffer against a slot/sequence-number reference
// model; ages are derived from allocation order rather than stored counters.
module tb_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pf_v, mem_req_rdy, mem_resp_v, dem_v;
    logic [AW-1:0] pf_addr, mem_resp_addr, dem_addr;
    logic [DW-1:0] mem_resp_data;
    logic          pf_drop, mem_req_v, dem_hit, dem_pending;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] dem_data;
    logic [OW-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prefetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pf_v         (pf_v),
        .pf_addr      (pf_addr),
        .pf_drop      (pf_drop),
        .mem_req_v    (mem_req_v),
        .mem_req_addr (mem_req_addr),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_v   (mem_resp_v),
        .mem_resp_addr(mem_resp_addr),
        .mem_resp_data(mem_resp_data),
        .dem_v        (dem_v),
        .dem_addr     (dem_addr),
        .dem_hit      (dem_hit),
        .dem_data     (dem_data),
        .dem_pending  (dem_pending),
        .occupancy    (occupancy)
    );

    // Reference model: 0 idle, 1 queued, 2 inflight, 3 ready.
    int            m_st   [DEPTH];
    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];
    int            m_seq  [DEPTH];
    int            m_cnt;
    logic          m_req_v;
    logic [AW-1:0] m_req_addr;
    logic          e_drop, e_hit, e_pend;
    logic [DW-1:0] e_data;
    int            e_occ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Age = allocations made since this entry's own, capped at DEPTH-1.
    function automatic int age(input int i);
        int a;
        a = m_cnt - m_seq[i] - 1;
        return (a > DEPTH - 1) ? DEPTH - 1 : a;
    endfunction

    function automatic int oldest(input int s);
        int best;
        best = -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_st[i] == s && (best < 0 || age(i) > age(best))) best = i;
        return best;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i]   = 0;
            m_addr[i] = '0;
            m_data[i] = '0;
            m_seq[i]  = 0;
        end
        m_cnt      = 0;
        m_req_v    = 1'b0;
        m_req_addr = '0;
        e_drop     = 1'b0;
        e_hit      = 1'b0;
        e_pend     = 1'b0;
        e_data     = '0;
        e_occ      = 0;
    endtask

    task automatic model_step();
        int   ns [DEPTH];
        logic dup, slot;
        int   al, is;
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (m_st[i] != 0 && m_addr[i] == pf_addr) dup = 1'b1;
        al = -1;
        if (pf_v && !dup) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (m_st[i] == 0) al = i;
            if (al < 0) al = oldest(3);
        end
        slot   = !m_req_v || mem_req_rdy;
        is     = slot ? oldest(1) : -1;
        e_drop = pf_v && (al < 0);
        e_hit  = 1'b0;
        e_pend = 1'b0;
        e_data = '0;
        for (int i = 0; i < DEPTH; i++) ns[i] = m_st[i];
        if (dem_v) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_st[i] != 0 && m_addr[i] == dem_addr) begin
                    if (m_st[i] == 3) begin
                        e_hit  = 1'b1;
                        e_data = m_data[i];
                        ns[i]  = 0;
                    end else if (m_st[i] == 2) begin
                        e_pend = 1'b1;
                    end else if (i != is) begin
                        ns[i] = 0;
                    end
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_resp_v && m_st[i] == 2 && m_addr[i] == mem_resp_addr) begin
                ns[i]     = 3;
                m_data[i] = mem_resp_data;
            end
        end
        if (is >= 0) begin
            ns[is]     = 2;
            m_req_v    = 1'b1;
            m_req_addr = m_addr[is];
        end else if (slot) begin
            m_req_v = 1'b0;
        end
        if (al >= 0) begin
            ns[al]     = 1;
            m_addr[al] = pf_addr;
            m_seq[al]  = m_cnt;
            m_cnt++;
        end
        e_occ = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = ns[i];
            if (ns[i] != 0) e_occ++;
        end
    endtask

    task automatic compare_all();
        check("pf_drop", pf_drop, e_drop);
        check("mem_req_v", mem_req_v, m_req_v);
        if (m_req_v) check("mem_req_addr", mem_req_addr, m_req_addr);
        check("dem_hit", dem_hit, e_hit);
        check("dem_data", dem_data, e_data);
        check("dem_pending", dem_pending, e_pend);
        check("occupancy", occupancy, e_occ);
    endtask

    task automatic zero_inputs();
        pf_v          = 1'b0;
        pf_addr       = '0;
        mem_req_rdy   = 1'b0;
        mem_resp_v    = 1'b0;
        mem_resp_addr = '0;
        mem_resp_data = '0;
        dem_v         = 1'b0;
        dem_addr      = '0;
    endtask

    task automatic cyc(input logic pv, input logic [AW-1:0] pa, input logic rdy,
                       input logic rv, input logic [AW-1:0] ra, input logic [DW-1:0] rd,
                       input logic dv, input logic [AW-1:0] da);
        @(negedge clk);
        pf_v          = pv;
        pf_addr       = pa;
        mem_req_rdy   = rdy;
        mem_resp_v    = rv;
        mem_resp_addr = ra;
        mem_resp_data = rd;
        dem_v         = dv;
        dem_addr      = da;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        zero_inputs();
        rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_mem_req_v", mem_req_v, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_pf_drop", pf_drop, 0);
        check("rst_dem_hit", dem_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        logic          pv, rdy, rv, dv;
        logic [AW-1:0] pa, ra, da;
        logic [DW-1:0] rd;
        int            infl[$];
        int            live[$];
        for (int i = 0; i < DEPTH; i++) begin
            if (m_st[i] == 2) infl.push_back(i);
            if (m_st[i] != 0) live.push_back(i);
        end
        pv  = ($urandom_range(0, 1) == 0);
        pa  = AW'($urandom_range(0, 11));
        rdy = ($urandom_range(0, 9) < 6);
        rv  = ($urandom_range(0, 9) < 4);
        ra  = AW'($urandom_range(0, 11));
        if (infl.size() > 0 && $urandom_range(0, 9) < 7)
            ra = m_addr[infl[$urandom_range(0, infl.size() - 1)]];
        rd  = DW'($urandom);
        dv  = ($urandom_range(0, 9) < 4);
        da  = AW'($urandom_range(0, 11));
        if (live.size() > 0 && $urandom_range(0, 1) == 0)
            da = m_addr[live[$urandom_range(0, live.size() - 1)]];
        cyc(pv, pa, rdy, rv, ra, rd, dv, da);
    endtask

    initial begin
        zero_inputs();
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("init_mem_req_v", mem_req_v, 0);
        check("init_occupancy", occupancy, 0);
        check("init_dem_data", dem_data, 0);
        check("init_pf_drop", pf_drop, 0);
        rst_n = 1'b1;

        // Single line: allocate, issue, respond, demand hit.
        cyc(1, 16'h0010, 1, 0, 0, 0, 0, 0);
        check("alloc_occ", occupancy, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        check("issue_v", mem_req_v, 1);
        check("issue_addr", mem_req_addr, 16'h0010);
        cyc(0, 0, 1, 1, 16'h0010, 16'hBEEF, 0, 0);
        check("ready_occ", occupancy, 1);
        cyc(0, 0, 1, 0, 0, 0, 1, 16'h0010);
        check("hit", dem_hit, 1);
        check("hit_data", dem_data, 16'hBEEF);
        check("hit_occ", occupancy, 0);
        do_reset();

        // Back-to-back duplicate.
        cyc(1, 16'h0020, 1, 0, 0, 0, 0, 0);
        cyc(1, 16'h0020, 1, 0, 0, 0, 0, 0);
        check("dup_drop", pf_drop, 1);
        check("dup_occ", occupancy, 1);
        do_reset();

        // Stalled memory port, full buffer, no READY victim.
        for (int a = 1; a <= 4; a++) begin
            cyc(1, AW'(a), 0, 0, 0, 0, 0, 0);
            if (a >= 2) check("stall_addr", mem_req_addr, 16'h0001);
        end
        cyc(1, 16'h0005, 0, 0, 0, 0, 0, 0);
        check("full_drop", pf_drop, 1);
        check("full_occ", occupancy, 4);
        check("stall_hold", mem_req_addr, 16'h0001);
        repeat (4) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 16'h0003, 16'h3333, 0, 0);
        cyc(0, 0, 1, 1, 16'h0002, 16'h2222, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 16'h0004);
        check("pend", dem_pending, 1);
        check("pend_hit", dem_hit, 0);
        cyc(0, 0, 1, 1, 16'h0001, 16'h1111, 0, 0);
        cyc(0, 0, 1, 1, 16'h0004, 16'h4444, 0, 0);
        check("all_ready_occ", occupancy, 4);
        cyc(1, 16'h0009, 0, 0, 0, 0, 0, 0);
        check("replace_drop", pf_drop, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0001);
        check("victim_miss", dem_hit, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0002);
        check("survivor_hit", dem_hit, 1);
        check("survivor_data", dem_data, 16'h2222);
        do_reset();

        // Reset with a request outstanding; the late response must match nothing.
        cyc(1, 16'h0040, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_req_v", mem_req_v, 1);
        do_reset();
        cyc(0, 0, 0, 1, 16'h0040, 16'h5555, 0, 0);
        check("post_rst_occ", occupancy, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0040);
        check("post_rst_hit", dem_hit, 0);

        for (int n = 0; n < 3000; n++) begin
            rand_cycle();
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
